// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART configuration receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic {
    ADDR,
    VALUE
  } frame_state_t;

  localparam int UART_CLK_DIV = 52;
  localparam int UART_N_PAR   = 5;

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: 2-FF synchroniser plus mid-bit sampling FSM.
// Optional even parity bit when UART_CFG_PARITY_EN is defined.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV,
  parameter int PAR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx,
  output logic             o_byte_vld,
  output logic [PAR_W-1:0] o_byte_data,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(PAR_W + 1);

  logic [1:0]       r_sync;
  logic [1:0]       r_armed;
  logic             r_prev;
  rx_state_t        r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [BIT_W-1:0] r_bits, w_bits;
  logic [PAR_W-1:0] r_shift, w_shift;
  logic             w_vld, w_ferr;
  logic             w_rx, w_fall;
`ifdef UART_CFG_PARITY_EN
  logic             r_par, w_par;
`endif

  assign w_rx        = r_sync[1];
  // r_prev only goes high once the synchroniser holds a real pin sample, so a
  // line that is low at reset release cannot fake a start edge.
  assign w_fall      = r_prev & ~w_rx;
  assign o_byte_data = r_shift;
  assign o_busy      = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '1;
      r_armed     <= '0;
      r_prev      <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bits      <= '0;
      r_shift     <= '0;
      o_byte_vld  <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_CFG_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_armed     <= {r_armed[0], 1'b1};
      r_prev      <= r_armed[1] & w_rx;
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bits      <= w_bits;
      r_shift     <= w_shift;
      o_byte_vld  <= w_vld;
      o_frame_err <= w_ferr;
`ifdef UART_CFG_PARITY_EN
      r_par       <= w_par;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bits  = r_bits;
    w_shift = r_shift;
    w_vld   = 1'b0;
    w_ferr  = 1'b0;
`ifdef UART_CFG_PARITY_EN
    w_par   = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state = START;
          w_cnt   = CNT_W'(CLK_DIV / 2 - 1);
        end
      end
      START: begin
        if (r_cnt == '0) begin
          if (!w_rx) begin
            w_state = DATA;
            w_cnt   = CNT_W'(CLK_DIV - 1);
            w_bits  = '0;
`ifdef UART_CFG_PARITY_EN
            w_par   = 1'b0;
`endif
          end else begin
            w_state = IDLE;
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == '0) begin
          w_shift = {w_rx, r_shift[PAR_W-1:1]};
          w_cnt   = CNT_W'(CLK_DIV - 1);
`ifdef UART_CFG_PARITY_EN
          w_par   = r_par ^ w_rx;
`endif
          if (r_bits == BIT_W'(PAR_W - 1)) begin
`ifdef UART_CFG_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          end else begin
            w_bits = r_bits + 1'b1;
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
`ifdef UART_CFG_PARITY_EN
      PARITY: begin
        if (r_cnt == '0) begin
          // Running XOR over data and parity bit is 0 for a valid even parity.
          w_par   = r_par ^ w_rx;
          w_cnt   = CNT_W'(CLK_DIV - 1);
          w_state = STOP;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (r_cnt == '0) begin
          w_state = IDLE;
`ifdef UART_CFG_PARITY_EN
          w_vld   = w_rx & ~r_par;
`else
          w_vld   = w_rx;
`endif
          w_ferr  = ~w_vld;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cfg_rx.sv
// UART configuration receiver: index/value write frames into a register bank.
// Define UART_CFG_PARITY_EN to expect an even parity bit on every byte.
module uart_cfg_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV      = UART_CLK_DIV,
  parameter int N_PAR        = UART_N_PAR,
  parameter int PAR_W        = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_data,
  output logic [N_PAR-1:0][PAR_W-1:0] par,
  output logic [N_PAR-1:0]            par_upd,
  output logic                        frame_err,
  output logic                        addr_err,
  output logic                        busy
);

  localparam int             TMO_LOAD = TIMEOUT_BITS * CLK_DIV - 1;
  localparam int             TMO_W    = $clog2(TMO_LOAD + 1);
  localparam logic [PAR_W:0] NPAR_L   = (PAR_W + 1)'(N_PAR);

  logic             w_byte_vld, w_ferr, w_rx_busy;
  logic [PAR_W-1:0] w_byte_data;
  frame_state_t     r_fstate, w_fstate;
  logic [PAR_W-1:0] r_idx, w_idx;
  logic [TMO_W-1:0] r_tmo, w_tmo;
  logic [N_PAR-1:0] w_upd;
  logic             w_aerr;

  uart_rx_byte #(
    .CLK_DIV (CLK_DIV),
    .PAR_W   (PAR_W)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (uart_data),
    .o_byte_vld  (w_byte_vld),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_ferr),
    .o_busy      (w_rx_busy)
  );

  assign frame_err = w_ferr;
  assign busy      = w_rx_busy | (r_fstate == VALUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fstate <= ADDR;
      r_idx    <= '0;
      r_tmo    <= '0;
      par      <= '0;
      par_upd  <= '0;
      addr_err <= 1'b0;
    end else begin
      r_fstate <= w_fstate;
      r_idx    <= w_idx;
      r_tmo    <= w_tmo;
      par_upd  <= w_upd;
      addr_err <= w_aerr;
      for (int unsigned i = 0; i < N_PAR; i++) begin
        if (w_upd[i]) par[i] <= w_byte_data;
      end
    end
  end

  always_comb begin
    w_fstate = r_fstate;
    w_idx    = r_idx;
    w_tmo    = r_tmo;
    case (r_fstate)
      ADDR: begin
        if (w_byte_vld) begin
          w_fstate = VALUE;
          w_idx    = w_byte_data;
          w_tmo    = TMO_W'(TMO_LOAD);
        end
      end
      VALUE: begin
        if (w_byte_vld || w_ferr) begin
          w_fstate = ADDR;
        end else if (!w_rx_busy) begin
          // Timeout only counts idle line time, never a byte in progress.
          if (r_tmo == '0) w_fstate = ADDR;
          else             w_tmo    = r_tmo - 1'b1;
        end
      end
      default: w_fstate = ADDR;
    endcase
  end

  always_comb begin
    w_upd = '0;
    for (int unsigned i = 0; i < N_PAR; i++) begin
      w_upd[i] = (r_fstate == VALUE) && w_byte_vld && (r_idx == PAR_W'(i));
    end
    w_aerr = (r_fstate == VALUE) && w_byte_vld && ({1'b0, r_idx} >= NPAR_L);
  end

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Directed self-checking bench for uart_cfg_rx with default parameters.
module tb_uart_cfg_rx;

  localparam int CD = 52;
  localparam int NP = 5;

  logic               clk;
  logic               rst;
  logic               uart_data;
  logic [NP-1:0][7:0] par;
  logic [NP-1:0]      par_upd;
  logic               frame_err;
  logic               addr_err;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int upd_cnt [NP];
  int aerr_cnt = 0;
  int ferr_cnt = 0;

  uart_cfg_rx #(
    .CLK_DIV      (CD),
    .N_PAR        (NP),
    .PAR_W        (8),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_data (uart_data),
    .par       (par),
    .par_upd   (par_upd),
    .frame_err (frame_err),
    .addr_err  (addr_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < NP; i++) upd_cnt[i] = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) if (par_upd[i]) upd_cnt[i] = upd_cnt[i] + 1;
      if (addr_err)  aerr_cnt = aerr_cnt + 1;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0]  idx;
    logic [7:0]  val;
    logic        stop_ok;
    logic [4:0]  exp_upd;
    logic        exp_aerr;
    logic        exp_ferr;
    logic [39:0] exp_par;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    uart_data = b;
    repeat (CD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_bad);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_CFG_PARITY_EN
    bit_time((^b) ^ par_bad);
`endif
    bit_time(stop_bit);
    uart_data = 1'b1;
  endtask

  int          u0 [NP];
  int          a0, f0, tot;
  logic [4:0]  got_upd;

  task automatic snap();
    for (int i = 0; i < NP; i++) u0[i] = upd_cnt[i];
    a0 = aerr_cnt;
    f0 = ferr_cnt;
  endtask

  task automatic deltas();
    tot = 0;
    for (int i = 0; i < NP; i++) begin
      got_upd[i] = (upd_cnt[i] != u0[i]);
      tot += upd_cnt[i] - u0[i];
    end
  endtask

  initial begin
    vecs[0] = '{8'h02, 8'h7F, 1'b1, 5'b00100, 1'b0, 1'b0, 40'h00_00_7F_00_00};
    vecs[1] = '{8'h09, 8'h11, 1'b1, 5'b00000, 1'b1, 1'b0, 40'h00_00_7F_00_00};
    vecs[2] = '{8'h00, 8'h33, 1'b1, 5'b00001, 1'b0, 1'b0, 40'h00_00_7F_00_33};
    vecs[3] = '{8'h03, 8'hA5, 1'b0, 5'b00000, 1'b0, 1'b1, 40'h00_00_7F_00_33};
    vecs[4] = '{8'h03, 8'hA5, 1'b1, 5'b01000, 1'b0, 1'b0, 40'h00_A5_7F_00_33};
    vecs[5] = '{8'hFF, 8'h01, 1'b1, 5'b00000, 1'b1, 1'b0, 40'h00_A5_7F_00_33};
    vecs[6] = '{8'h04, 8'hC3, 1'b1, 5'b10000, 1'b0, 1'b0, 40'hC3_A5_7F_00_33};

    uart_data = 1'b1;
    rst       = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_par", 64'(par), 64'h0);
    chk("reset_upd", 64'(par_upd), 64'h0);
    chk("reset_ferr", 64'(frame_err), 64'h0);
    chk("reset_aerr", 64'(addr_err), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    repeat (2 * CD) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      snap();
      send_byte(vecs[v].idx, 1'b1, 1'b0);
      send_byte(vecs[v].val, vecs[v].stop_ok, 1'b0);
      repeat (2 * CD) @(negedge clk);
      deltas();
      chk($sformatf("vec%0d_par", v), 64'(par), 64'(vecs[v].exp_par));
      chk($sformatf("vec%0d_upd", v), 64'(got_upd), 64'(vecs[v].exp_upd));
      chk($sformatf("vec%0d_upd_total", v), 64'(tot), 64'($countones(vecs[v].exp_upd)));
      chk($sformatf("vec%0d_aerr", v), 64'(aerr_cnt - a0), 64'(vecs[v].exp_aerr));
      chk($sformatf("vec%0d_ferr", v), 64'(ferr_cnt - f0), 64'(vecs[v].exp_ferr));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'h0);
    end

    // Index byte left dangling past the value-byte timeout.
    snap();
    send_byte(8'h01, 1'b1, 1'b0);
    repeat (5 * CD) @(negedge clk);
    chk("tmo_busy_wait", 64'(busy), 64'h1);
    repeat (20 * CD) @(negedge clk);
    chk("tmo_busy_expired", 64'(busy), 64'h0);
    send_byte(8'h04, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (2 * CD) @(negedge clk);
    deltas();
    chk("tmo_par", 64'(par), 64'h55_A5_7F_00_33);
    chk("tmo_upd", 64'(got_upd), 64'b10000);
    chk("tmo_aerr", 64'(aerr_cnt - a0), 64'h0);

    // Short low glitch must be rejected at the start-bit sample.
    snap();
    uart_data = 1'b0;
    repeat (10) @(negedge clk);
    uart_data = 1'b1;
    repeat (CD) @(negedge clk);
    deltas();
    chk("glitch_busy", 64'(busy), 64'h0);
    chk("glitch_upd", 64'(tot), 64'h0);
    chk("glitch_aerr", 64'(aerr_cnt - a0), 64'h0);
    chk("glitch_ferr", 64'(ferr_cnt - f0), 64'h0);

`ifdef UART_CFG_PARITY_EN
    snap();
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h99, 1'b1, 1'b1);
    repeat (2 * CD) @(negedge clk);
    deltas();
    chk("parity_ferr", 64'(ferr_cnt - f0), 64'h1);
    chk("parity_upd", 64'(tot), 64'h0);
    chk("parity_par", 64'(par), 64'h55_A5_7F_00_33);
`endif

    // Reset in the middle of a value byte.
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    repeat (2 * CD) @(negedge clk);
    chk("prerst_par", 64'(par), 64'h55_A5_7F_00_12);
    send_byte(8'h00, 1'b1, 1'b0);
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_par", 64'(par), 64'h0);
    chk("midrst_upd", 64'(par_upd), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    uart_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3 * CD) @(negedge clk);
    snap();
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    repeat (2 * CD) @(negedge clk);
    deltas();
    chk("postrst_par", 64'(par), 64'h00_00_00_00_12);
    chk("postrst_upd", 64'(got_upd), 64'b00001);
    chk("postrst_busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cfg_rx.md
# uart_cfg_rx

Parametrised UART configuration receiver for the DRSSTC controller. It decodes addressed two-byte write frames (index byte, then value byte) from a serial line into a bank of `N_PAR` configuration registers, for example ref_gen, phase_shift, ocd_lvl, inter_freq and inter_duty. Every write is positional-independent and validated, so a lost byte costs one write rather than shifting every later parameter. It sits between the board UART pin and the control blocks that consume the parameters.

## Interface
- `CLK_DIV`, 52: clk cycles per bit; must be ≥ 4.
- `N_PAR`, 5: number of configuration registers; must be ≤ 256.
- `PAR_W`, 8: data bits per UART byte and per register.
- `TIMEOUT_BITS`, 20: bit-times allowed between the end of the index byte and the start bit of the value byte.

- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `uart_data`  in  1: serial line; idles high; LSB first.
- `par`  out  N_PAR×PAR_W: register bank, packed 2-D `[N_PAR-1:0][PAR_W-1:0]`.
- `par_upd`  out  N_PAR: one-cycle strobe per register on write.
- `frame_err`  out  1: one-cycle pulse on a byte error (stop bit, or parity when that feature is enabled).
- `addr_err`  out  1: one-cycle pulse when a frame is dropped because its index is ≥ N_PAR.
- `busy`  out  1: high while a byte is being received or a value byte is awaited.

## Operation
- The input passes through a 2-FF synchroniser. Both FFs reset to 1.
- Byte receiver FSM states: IDLE, START, DATA, PARITY (only when parity is enabled), STOP.
  - IDLE → START on a falling edge of the synchronised line. The bit counter loads CLK_DIV/2−1.
  - START: when the counter reaches 0, the line is sampled.
    - Low: go to DATA and load CLK_DIV−1.
    - High: treat as a glitch and return to IDLE with no pulse.
  - DATA: sample once per CLK_DIV cycles into a right-shift register, MSB in, so the first received bit ends at bit 0. After PAR_W samples, go to PARITY or STOP.
  - STOP: sample at mid-bit. High gives `byte_vld`. Low gives `frame_err`. In both cases return to IDLE immediately, so a back-to-back start edge is caught.
- Frame FSM states: ADDR, VALUE.
  - ADDR + `byte_vld`: latch the index, go to VALUE, load the timeout counter with TIMEOUT_BITS×CLK_DIV−1.
  - VALUE + `byte_vld`:
    - Index < N_PAR: write `par[idx]` and pulse `par_upd[idx]`.
    - Otherwise: pulse `addr_err`.
    - In both cases return to ADDR.
  - VALUE timeout: the counter decrements only while the byte receiver is in IDLE. If it reaches 0, return to ADDR silently.
  - `frame_err` in any frame state returns the frame FSM to ADDR; nothing is written.
- The index comparison uses the full PAR_W-bit byte against N_PAR, so an index of 255 with N_PAR=5 is rejected.

## Timing
- Reset values: `par` all 0, `par_upd` 0, `frame_err` 0, `addr_err` 0, `busy` 0. Both FSMs are in their first state (IDLE, ADDR).
- Sample point: falling edge seen on synchronised line at cycle t0. Bit k (start = 0) is sampled at t0 + CLK_DIV/2 + k·CLK_DIV.
- Sampling happens 2 cycles after the pin change because of the synchroniser.
- `byte_vld` and `frame_err` go high the cycle after the stop sample.
- `par[idx]` updates and `par_upd[idx]` pulses one cycle after the value byte's `byte_vld`.
- `busy` = byte FSM ≠ IDLE, or frame FSM = VALUE.
- Asserting `rst` mid-byte or mid-frame aborts everything immediately. Registers return to 0.
- The rest of the frame after reset release is ignored until the line is seen high and then falls again.

## Configuration
- `UART_CFG_PARITY_EN` defined:
  - An even-parity bit follows the data bits, sampled in the PARITY state.
  - A mismatch gives a `frame_err` pulse at the stop sample and the byte is discarded.
  - Frame length is 1 + PAR_W + 1 + 1 bits.
- `UART_CFG_PARITY_EN` undefined:
  - No PARITY state; frame length is 1 + PAR_W + 1 bits.
  - `frame_err` reports only stop-bit errors.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `frame_state_t` enum (ADDR, VALUE).
  - Default constants `UART_CLK_DIV`=52 and `UART_N_PAR`=5.
- Sub-module `uart_rx_byte` (synchroniser plus byte FSM) outputs `byte_vld`, `byte_data` and `frame_err`.
- `uart_cfg_rx` holds the frame FSM, the timeout counter and the register bank.

## Test plan
- Frame 0x02, 0x7F at CLK_DIV=52 → `par[2]`=0x7F, `par_upd`=5'b00100 for exactly one cycle, other registers 0, `addr_err` 0.
- Frame 0x09, 0x11 with N_PAR=5 → `addr_err` pulses once, all `par` unchanged. A following 0x00, 0x33 writes `par[0]`=0x33.
- Index 0x01, then a 25-bit-time gap (TIMEOUT_BITS=20), then 0x04, 0x55 → `par[4]`=0x55 and `par[1]` unchanged.
- Value byte with the stop bit forced low → `frame_err` pulse, no write. The next frame 0x03, 0xA5 gives `par[3]`=0xA5.
- 10-cycle low glitch on an idle line → no `busy` after the glitch window, no pulses. With `UART_CFG_PARITY_EN`, a wrong parity bit on the value byte gives `frame_err` and no write.
- `rst` asserted mid-value-byte after `par[0]`=0x12 → all outputs 0 immediately. After release a full frame 0x00, 0x12 is received correctly.
